hms_clock_display: RTL and testbench
====================================

Name: hms_clock_display

Overview:
- Parametrised real-time-of-day clock core. Produces HH:MM:SS on six 7-segment digit outputs.
- Keeps time in cascaded BCD counters driven by a 1 Hz tick from an internal prescaler.
- Adds a run/pause control, 12/24-hour display mode, a validated time-load interface, day-wrap and second-tick strobes, and optional hour leading-zero blanking.
- Sits between the board clock/reset and the six 7-segment display drivers.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency; one tick every CLK_HZ cycles (minimum 2).
- PRESC_W, 26, prescaler counter width; must satisfy 2^PRESC_W >= CLK_HZ.
- BLANK_LZ, 0, when 1 the hour-tens digit is blanked (all segments off) when its value is 0.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- run  input  1  1 = timekeeping advances; 0 = prescaler and time frozen.
- mode_12h  input  1  1 = 12-hour display; 0 = 24-hour display.
- set_valid  input  1  single-cycle request to load the time.
- set_hour  input  5  binary hour, 0-23.
- set_min  input  6  binary minute, 0-59.
- set_sec  input  6  binary second, 0-59.
- set_err  output  1  one-cycle pulse when a load request is out of range.
- sec_tick  output  1  one-cycle pulse on each second advance.
- day_wrap  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 transition.
- pm  output  1  1 when the internal hour is >= 12, in both display modes.
- led_a  output  7  seconds ones digit.
- led_b  output  7  seconds tens digit.
- led_c  output  7  minutes ones digit.
- led_d  output  7  minutes tens digit.
- led_e  output  7  hours ones digit.
- led_f  output  7  hours tens digit.

Behaviour:
- Reset is synchronous and active-low on reset; clock is clk.
- Reset values:
  - time = 00:00:00, prescaler = 0.
  - set_err, sec_tick, day_wrap and pm all 0.
  - Displays update on the first clock edge after reset: 24h mode shows 00:00:00; 12h mode shows 12:00:00.
- Segment encoding:
  - Bit 6 = a ... bit 0 = g; active-low (0 = lit).
  - Digit patterns, 0 through 9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
  - Blank = 1111111.
- Prescaler:
  - When run=1, it increments each cycle.
  - On reaching CLK_HZ-1 it returns to 0 and asserts an internal tick for that cycle.
  - When run=0, it holds its value and no tick occurs.
- Time counters:
  - Six BCD digits: s0 0-9, s1 0-5, m0 0-9, m1 0-5, h1:h0 00-23.
  - On tick, s0 increments; each digit carries into the next at its limit.
  - Hour goes 09 -> 10, 19 -> 20, and 23 -> 00.
  - 23:59:59 + tick gives 00:00:00 with day_wrap=1 in the same cycle as sec_tick.
- sec_tick is registered and pulses in the cycle the time registers take the new value.
- Load:
  - On set_valid=1 with all fields in range, the time takes the binary-to-BCD converted values on the next edge and the prescaler clears to 0.
  - If any field is out of range, time is unchanged and set_err=1 for one cycle.
  - A valid load takes priority over a simultaneous tick; that tick is discarded, and sec_tick and day_wrap stay 0 that cycle.
  - Load is accepted regardless of run.
- Display path:
  - Registered; led_* and pm reflect the time registers with 1 cycle of latency.
  - mode_12h is sampled combinationally into that register stage, so a mode change is visible after 1 cycle.
- 12h mapping of the displayed hour: internal 0 -> 12; 1-12 unchanged; 13-23 -> hour-12.
- BLANK_LZ=1: led_f shows blank when the displayed hour-tens digit is 0, in either mode.
- BCD digit values outside 0-9 cannot occur. The decoder default still drives blank.

Optional Feature:
- Macro: HMS_CLOCK_ALARM_EN.
- When defined:
  - Extra ports: alarm_set (in, 1), alarm_hour (in, 5), alarm_min (in, 6), alarm_on (in, 1), alarm (out, 1).
  - alarm_set=1 with in-range values latches the alarm HH:MM. Out-of-range values pulse set_err.
  - alarm rises on the tick that makes time equal alarm HH:MM:00 while alarm_on=1.
  - alarm stays 1 until alarm_on=0 or reset.
  - Alarm reset value is 00:00, with alarm=0.
- When undefined: no alarm ports or logic exist. All other behaviour is identical.

Decomposition:
- Package hms_clock_pkg:
  - SEG_BLANK and the 10-entry digit pattern constant.
  - Digit limit localparams (9, 5, 23).
  - A bcd-digit typedef, logic [3:0].
- One sub-module, seg7_decode: combinational, 4-bit BCD in, blank flag in, 7-bit out. It is instantiated six times.

Test Plan:
1. CLK_HZ=4; release reset, run=1 -> sec_tick every 4 cycles; after 40 cycles time reads 00:00:10; led_a=0000001, led_b=1001111.
2. Load 23:59:58, then run 8 cycles -> 23:59:59, then 00:00:00 with day_wrap=1 in exactly one cycle; pm goes 1 -> 0.
3. Load hour=24, min=10 -> set_err pulses for 1 cycle, time unchanged. Load 12:60:00 -> set_err again.
4. mode_12h=1 with times 00:00:00, 12:30:00 and 13:05:00 -> displayed hours 12, 12, 01; pm=0, 1, 1. With BLANK_LZ=1, 13:05 gives led_f=1111111.
5. Apply set_valid in the same cycle as a tick -> loaded value wins; sec_tick=0. Assert run=0 for 10 cycles -> time and prescaler frozen.
6. With HMS_CLOCK_ALARM_EN: set alarm 00:01, alarm_on=1 -> alarm rises at the tick producing 00:01:00 and holds until alarm_on is dropped. Reset mid-count -> all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/hms_clock_pkg.sv
// hms_clock_pkg
//   Shared types, constants and helpers for the HH:MM:SS clock core.
//   - bcd_t       : one BCD digit (0-9 in practice).
//   - SEG_BLANK   : active-low 7-segment pattern with every segment off.
//   - DIGIT_PAT   : active-low patterns for 0..9, bit 6 = segment a, bit 0 = g.
//   - ONES_MAX / TENS_MAX / HOUR_LAST : roll-over limits of the digit chain.
//   - bin_to_bcd2 : 6-bit binary (0-63) to two packed BCD digits {tens, ones}.
package hms_clock_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] DIGIT_PAT [0:9] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100   // 9
    };

    localparam bcd_t ONES_MAX  = 4'd9;   // seconds/minutes/hours ones digit
    localparam bcd_t TENS_MAX  = 4'd5;   // seconds/minutes tens digit
    localparam int   HOUR_LAST = 23;     // last hour of the day

    localparam bcd_t HOUR_TENS_LAST = bcd_t'(HOUR_LAST / 10);
    localparam bcd_t HOUR_ONES_LAST = bcd_t'(HOUR_LAST % 10);

    // Comparison chain instead of a divider; callers only pass values < 64.
    function automatic logic [7:0] bin_to_bcd2(input logic [5:0] v);
        bcd_t       tens;
        logic [5:0] ones;
        if (v >= 6'd60)      tens = 4'd6;
        else if (v >= 6'd50) tens = 4'd5;
        else if (v >= 6'd40) tens = 4'd4;
        else if (v >= 6'd30) tens = 4'd3;
        else if (v >= 6'd20) tens = 4'd2;
        else if (v >= 6'd10) tens = 4'd1;
        else                 tens = 4'd0;
        ones = v - ({2'b00, tens} * 6'd10);
        return {tens, ones[3:0]};
    endfunction

endpackage

// File: rtl/hms_clock_display_seg7_decode.sv
// seg7_decode
//   Combinational BCD digit to active-low 7-segment decoder.
//   Ports:
//     digit : BCD digit in (0-9 expected).
//     blank : 1 forces all segments off.
//     seg   : segment pattern, bit 6 = a ... bit 0 = g, 0 = lit.
//   Codes 10-15 never occur from the counters; they still decode to blank.
module seg7_decode
    import hms_clock_pkg::*;
(
    input  bcd_t       digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank && (digit <= ONES_MAX)) begin
            seg = DIGIT_PAT[digit];
        end
    end

endmodule

// File: rtl/hms_clock_display.sv
// hms_clock_display
//   Time-of-day clock core: a prescaler turns clk into a 1 Hz tick that
//   advances six cascaded BCD counters (HH:MM:SS); the time is shown on six
//   registered 7-segment outputs in 12- or 24-hour form.
//
//   Parameters:
//     CLK_HZ   : clk cycles per second (>= 2).
//     PRESC_W  : prescaler width, 2**PRESC_W >= CLK_HZ.
//     BLANK_LZ : 1 blanks led_f whenever the displayed hour-tens digit is 0.
//
//   Ports:
//     clk, reset          : clock, synchronous active-low reset.
//     run                 : 1 = prescaler and time advance, 0 = frozen.
//     mode_12h            : 1 = 12-hour display, 0 = 24-hour display.
//     set_valid           : load request for set_hour/set_min/set_sec.
//     set_hour/min/sec    : binary load values (0-23 / 0-59 / 0-59).
//     set_err             : one-cycle pulse for an out-of-range load request.
//     sec_tick            : one-cycle pulse in the cycle the time advances.
//     day_wrap            : one-cycle pulse with the 23:59:59 -> 00:00:00 step.
//     pm                  : internal hour >= 12 (1 cycle latency, like leds).
//     led_a..led_f        : sec ones, sec tens, min ones, min tens,
//                           hour ones, hour tens (active-low segments).
//
//   Optional feature, enabled by defining HMS_CLOCK_ALARM_EN:
//     alarm_set, alarm_hour, alarm_min : load alarm HH:MM (range checked,
//                                        a bad request pulses set_err).
//     alarm_on                         : arms the alarm; 0 clears it.
//     alarm                            : rises on the tick that reaches
//                                        alarm HH:MM:00, holds until
//                                        alarm_on drops or reset.
//
//   Request semantics: set_valid and alarm_set are single-cycle requests with
//   no ready/back-pressure; a request is always consumed on the edge where it
//   is high. In-range requests take effect on that edge, out-of-range ones
//   leave state untouched and raise set_err on the same edge. A valid time
//   load wins over a coincident tick, which is then dropped.
module hms_clock_display
    import hms_clock_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int PRESC_W  = 26,
    parameter int BLANK_LZ = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       mode_12h,
    input  logic       set_valid,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_min,
    input  logic [5:0] set_sec,
`ifdef HMS_CLOCK_ALARM_EN
    input  logic       alarm_set,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       alarm_on,
    output logic       alarm,
`endif
    output logic       set_err,
    output logic       sec_tick,
    output logic       day_wrap,
    output logic       pm,
    output logic [6:0] led_a,
    output logic [6:0] led_b,
    output logic [6:0] led_c,
    output logic [6:0] led_d,
    output logic [6:0] led_e,
    output logic [6:0] led_f
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);

    // ------------------------------------------------------------------
    // Prescaler, load decode and time registers
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0] presc;
    bcd_t s0, s1, m0, m1, h0, h1;
    bcd_t n_s0, n_s1, n_m0, n_m1, n_h0, n_h1;
    logic n_wrap;
    logic tick;
    logic set_ok;
    logic load;
    logic set_bad;
    logic [7:0] ld_h, ld_m, ld_s;

    assign tick   = run && (presc == PRESC_LAST);
    assign set_ok = (set_hour < 5'd24) && (set_min < 6'd60) && (set_sec < 6'd60);
    assign load   = set_valid && set_ok;

    assign ld_h = bin_to_bcd2({1'b0, set_hour});
    assign ld_m = bin_to_bcd2(set_min);
    assign ld_s = bin_to_bcd2(set_sec);

    // Carry chain: each digit only moves when every lower digit is at its
    // limit, so the nesting mirrors the ripple from seconds to hours.
    always_comb begin
        n_s0   = s0;
        n_s1   = s1;
        n_m0   = m0;
        n_m1   = m1;
        n_h0   = h0;
        n_h1   = h1;
        n_wrap = 1'b0;
        if (tick) begin
            if (s0 != ONES_MAX) begin
                n_s0 = s0 + 4'd1;
            end else begin
                n_s0 = '0;
                if (s1 != TENS_MAX) begin
                    n_s1 = s1 + 4'd1;
                end else begin
                    n_s1 = '0;
                    if (m0 != ONES_MAX) begin
                        n_m0 = m0 + 4'd1;
                    end else begin
                        n_m0 = '0;
                        if (m1 != TENS_MAX) begin
                            n_m1 = m1 + 4'd1;
                        end else begin
                            n_m1 = '0;
                            // 23 -> 00 must be checked before the generic
                            // ones-digit roll, which would give 24.
                            if ((h1 == HOUR_TENS_LAST) && (h0 == HOUR_ONES_LAST)) begin
                                n_h1   = '0;
                                n_h0   = '0;
                                n_wrap = 1'b1;
                            end else if (h0 == ONES_MAX) begin
                                n_h0 = '0;
                                n_h1 = h1 + 4'd1;
                            end else begin
                                n_h0 = h0 + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc    <= '0;
            s0       <= '0;
            s1       <= '0;
            m0       <= '0;
            m1       <= '0;
            h0       <= '0;
            h1       <= '0;
            sec_tick <= 1'b0;
            day_wrap <= 1'b0;
            set_err  <= 1'b0;
        end else begin
            set_err <= set_bad;
            if (load) begin
                presc    <= '0;
                {h1, h0} <= ld_h;
                {m1, m0} <= ld_m;
                {s1, s0} <= ld_s;
                sec_tick <= 1'b0;
                day_wrap <= 1'b0;
            end else begin
                if (run) begin
                    presc <= tick ? '0 : presc + PRESC_W'(1);
                end
                s0       <= n_s0;
                s1       <= n_s1;
                m0       <= n_m0;
                m1       <= n_m1;
                h0       <= n_h0;
                h1       <= n_h1;
                sec_tick <= tick;
                day_wrap <= n_wrap;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional alarm
    // ------------------------------------------------------------------
`ifdef HMS_CLOCK_ALARM_EN
    logic       alarm_ok;
    logic       alarm_hit;
    logic [7:0] alm_h;
    logic [7:0] alm_m;

    assign alarm_ok = (alarm_hour < 5'd24) && (alarm_min < 6'd60);
    assign set_bad  = (set_valid && !set_ok) || (alarm_set && !alarm_ok);

    // Compare against the post-tick time so the alarm rises in the same
    // cycle the display registers receive HH:MM:00.
    assign alarm_hit = tick && !load &&
                       ({n_h1, n_h0} == alm_h) && ({n_m1, n_m0} == alm_m) &&
                       (n_s1 == 4'd0) && (n_s0 == 4'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            alm_h <= '0;
            alm_m <= '0;
            alarm <= 1'b0;
        end else begin
            if (alarm_set && alarm_ok) begin
                alm_h <= bin_to_bcd2({1'b0, alarm_hour});
                alm_m <= bin_to_bcd2(alarm_min);
            end
            alarm <= alarm_on && (alarm || alarm_hit);
        end
    end
`else
    assign set_bad = set_valid && !set_ok;
`endif

    // ------------------------------------------------------------------
    // Display path: hour mapping, decoders, output register
    // ------------------------------------------------------------------
    logic [4:0] hour_bin;
    logic [4:0] disp_hour;
    logic [7:0] disp_h_bcd;
    logic       blank_h1;
    logic [6:0] seg_a, seg_b, seg_c, seg_d, seg_e, seg_f;

    always_comb begin
        hour_bin  = (5'(h1) * 5'd10) + 5'(h0);
        disp_hour = hour_bin;
        if (mode_12h) begin
            if (hour_bin == 5'd0) begin
                disp_hour = 5'd12;
            end else if (hour_bin > 5'd12) begin
                disp_hour = hour_bin - 5'd12;
            end
        end
    end

    assign disp_h_bcd = bin_to_bcd2({1'b0, disp_hour});
    assign blank_h1   = (BLANK_LZ != 0) && (disp_h_bcd[7:4] == 4'd0);

    seg7_decode u_dec_a (.digit(s0),               .blank(1'b0),     .seg(seg_a));
    seg7_decode u_dec_b (.digit(s1),               .blank(1'b0),     .seg(seg_b));
    seg7_decode u_dec_c (.digit(m0),               .blank(1'b0),     .seg(seg_c));
    seg7_decode u_dec_d (.digit(m1),               .blank(1'b0),     .seg(seg_d));
    seg7_decode u_dec_e (.digit(disp_h_bcd[3:0]),  .blank(1'b0),     .seg(seg_e));
    seg7_decode u_dec_f (.digit(disp_h_bcd[7:4]),  .blank(blank_h1), .seg(seg_f));

    always_ff @(posedge clk) begin
        if (!reset) begin
            led_a <= SEG_BLANK;
            led_b <= SEG_BLANK;
            led_c <= SEG_BLANK;
            led_d <= SEG_BLANK;
            led_e <= SEG_BLANK;
            led_f <= SEG_BLANK;
            pm    <= 1'b0;
        end else begin
            led_a <= seg_a;
            led_b <= seg_b;
            led_c <= seg_c;
            led_d <= seg_d;
            led_e <= seg_e;
            led_f <= seg_f;
            pm    <= (hour_bin >= 5'd12);
        end
    end

endmodule

// File: tb/tb_hms_clock_display.sv
`timescale 1ns/1ps
module tb_hms_clock_display;

  localparam int CLK_HZ  = 4;
  localparam int PRESC_W = 3;
  localparam int W       = 47;
  localparam logic [6:0] BLANK = 7'b1111111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset     = 1'b0;
  logic       run       = 1'b0;
  logic       mode_12h  = 1'b0;
  logic       set_valid = 1'b0;
  logic [4:0] set_hour  = '0;
  logic [5:0] set_min   = '0;
  logic [5:0] set_sec   = '0;
  logic       alarm_set  = 1'b0;
  logic [4:0] alarm_hour = '0;
  logic [5:0] alarm_min  = '0;
  logic       alarm_on   = 1'b0;

  logic       set_err, sec_tick, day_wrap, pm, alarm_o;
  logic [6:0] led_a, led_b, led_c, led_d, led_e, led_f;
  logic       z_set_err, z_sec_tick, z_day_wrap, z_pm, z_alarm_o;
  logic [6:0] z_led_a, z_led_b, z_led_c, z_led_d, z_led_e, z_led_f;

  hms_clock_display #(.CLK_HZ(CLK_HZ), .PRESC_W(PRESC_W), .BLANK_LZ(0)) dut (
    .clk(clk), .reset(reset), .run(run), .mode_12h(mode_12h),
    .set_valid(set_valid), .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
`ifdef HMS_CLOCK_ALARM_EN
    .alarm_set(alarm_set), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
    .alarm_on(alarm_on), .alarm(alarm_o),
`endif
    .set_err(set_err), .sec_tick(sec_tick), .day_wrap(day_wrap), .pm(pm),
    .led_a(led_a), .led_b(led_b), .led_c(led_c), .led_d(led_d), .led_e(led_e), .led_f(led_f)
  );

  hms_clock_display #(.CLK_HZ(CLK_HZ), .PRESC_W(PRESC_W), .BLANK_LZ(1)) dut_lz (
    .clk(clk), .reset(reset), .run(run), .mode_12h(mode_12h),
    .set_valid(set_valid), .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
`ifdef HMS_CLOCK_ALARM_EN
    .alarm_set(alarm_set), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
    .alarm_on(alarm_on), .alarm(z_alarm_o),
`endif
    .set_err(z_set_err), .sec_tick(z_sec_tick), .day_wrap(z_day_wrap), .pm(z_pm),
    .led_a(z_led_a), .led_b(z_led_b), .led_c(z_led_c), .led_d(z_led_d), .led_e(z_led_e), .led_f(z_led_f)
  );

`ifndef HMS_CLOCK_ALARM_EN
  assign alarm_o   = 1'b0;
  assign z_alarm_o = 1'b0;
`endif

  // ---------------- reference model ----------------
  // Time is kept as seconds-of-day; digits come from division.
  int    tod = 0;
  int    mpresc = 0;
  int    al_h = 0, al_m = 0;
  bit    m_alarm = 1'b0;
  string phase = "reset";

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_lz_q[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return BLANK;
    endcase
  endfunction

  always @(posedge clk) begin : model
    int hour, dh, sec, mn;
    bit ld_ok, tk, st, dw, err, pm_e, hit;
    logic [6:0] la, lb, lc, ld, le, lf, lf_z;
    if (!reset) begin
      tod = 0; mpresc = 0; al_h = 0; al_m = 0; m_alarm = 1'b0;
      exp_q.push_back({4'b0000, {6{BLANK}}, 1'b0});
      exp_lz_q.push_back({4'b0000, {6{BLANK}}, 1'b0});
    end else begin
      hour = tod / 3600;
      mn   = (tod / 60) % 60;
      sec  = tod % 60;
      dh   = hour;
      if (mode_12h) dh = (hour % 12 == 0) ? 12 : hour % 12;
      la = pat(sec % 10); lb = pat(sec / 10);
      lc = pat(mn % 10);  ld = pat(mn / 10);
      le = pat(dh % 10);  lf = pat(dh / 10);
      lf_z = (dh / 10 == 0) ? BLANK : lf;
      pm_e = (hour >= 12);

      ld_ok = set_valid && int'(set_hour) < 24 && int'(set_min) < 60 && int'(set_sec) < 60;
      err   = set_valid && !ld_ok;
`ifdef HMS_CLOCK_ALARM_EN
      err = err || (alarm_set && !(int'(alarm_hour) < 24 && int'(alarm_min) < 60));
`endif
      tk = run && (mpresc == CLK_HZ - 1);
      st = 1'b0; dw = 1'b0;
      if (ld_ok) begin
        tod = int'(set_hour) * 3600 + int'(set_min) * 60 + int'(set_sec);
        mpresc = 0;
      end else begin
        if (run) mpresc = (mpresc + 1) % CLK_HZ;
        if (tk) begin
          dw  = (tod == 86399);
          tod = (tod + 1) % 86400;
          st  = 1'b1;
        end
      end
`ifdef HMS_CLOCK_ALARM_EN
      hit = st && (tod == al_h * 3600 + al_m * 60);
      m_alarm = alarm_on && (m_alarm || hit);
      if (alarm_set && int'(alarm_hour) < 24 && int'(alarm_min) < 60) begin
        al_h = int'(alarm_hour);
        al_m = int'(alarm_min);
      end
`else
      hit = 1'b0;
`endif
      exp_q.push_back({err, st, dw, pm_e, lf, le, ld, lc, lb, la, m_alarm});
      exp_lz_q.push_back({err, st, dw, pm_e, lf_z, le, ld, lc, lb, la, m_alarm});
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : monitor
    logic [W-1:0] e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {set_err, sec_tick, day_wrap, pm, led_f, led_e, led_d, led_c, led_b, led_a, alarm_o};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s main t=%0t: got %h expected %h", phase, $time, a, e);
      end
    end
    if (exp_lz_q.size() != 0) begin
      e = exp_lz_q.pop_front();
      a = {z_set_err, z_sec_tick, z_day_wrap, z_pm, z_led_f, z_led_e, z_led_d, z_led_c,
           z_led_b, z_led_a, z_alarm_o};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s blank_lz t=%0t: got %h expected %h", phase, $time, a, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_load(input int h, input int m, input int s);
    set_hour  = 5'(h);
    set_min   = 6'(m);
    set_sec   = 6'(s);
    set_valid = 1'b1;
    @(negedge clk);
    set_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Positions stimulus so the next edge carries a tick.
  task automatic wait_tick_edge();
    for (int i = 0; i < CLK_HZ + 2 && mpresc != CLK_HZ - 1; i++) @(negedge clk);
    if (mpresc != CLK_HZ - 1) begin
      miscompares++;
      $display("FAIL wait_tick_edge: presc %0d expected %0d", mpresc, CLK_HZ - 1);
    end
  endtask

`ifdef HMS_CLOCK_ALARM_EN
  task automatic do_alarm_set(input int h, input int m);
    alarm_hour = 5'(h);
    alarm_min  = 6'(m);
    alarm_set  = 1'b1;
    @(negedge clk);
    alarm_set  = 1'b0;
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin : stim
    idle(3);
    reset = 1'b1; run = 1'b1;
    phase = "count";
    idle(44);

    phase = "day_wrap";
    do_load(23, 59, 58);
    idle(10);

    phase = "set_err";
    do_load(24, 10, 0);
    idle(1);
    do_load(12, 60, 0);
    do_load(5, 5, 60);
    idle(3);

    phase = "mode_12h";
    run = 1'b0; mode_12h = 1'b1;
    do_load(0, 0, 0);   idle(2);
    do_load(12, 30, 0); idle(2);
    do_load(13, 5, 0);  idle(2);
    do_load(9, 59, 59); idle(2);
    mode_12h = 1'b0;    idle(2);
    do_load(21, 7, 3);  idle(1);
    mode_12h = 1'b1;    idle(2);

    phase = "load_vs_tick";
    run = 1'b1;
    wait_tick_edge();
    do_load(7, 8, 9);
    idle(6);

    phase = "freeze";
    idle(2);
    run = 1'b0; idle(10);
    run = 1'b1; idle(9);

`ifdef HMS_CLOCK_ALARM_EN
    phase = "alarm";
    mode_12h = 1'b0;
    do_alarm_set(24, 1);
    do_alarm_set(0, 1);
    alarm_on = 1'b1;
    do_load(0, 0, 55);
    idle(30);
    alarm_on = 1'b0; idle(3);
    alarm_on = 1'b1; idle(4);
    phase = "reset_mid";
    reset = 1'b0; idle(2);
    reset = 1'b1; idle(6);
`endif

    phase = "random";
    for (int i = 0; i < 2500; i++) begin
      run      = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 31) == 0) mode_12h = ~mode_12h;
      reset    = ($urandom_range(0, 299) != 0);
      set_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 0) begin
        set_hour = 5'd23; set_min = 6'd59; set_sec = 6'($urandom_range(50, 61));
      end else begin
        set_hour = 5'($urandom_range(0, 25));
        set_min  = 6'($urandom_range(0, 62));
        set_sec  = 6'($urandom_range(0, 62));
      end
`ifdef HMS_CLOCK_ALARM_EN
      alarm_set  = ($urandom_range(0, 49) == 0);
      alarm_hour = 5'($urandom_range(0, 24));
      alarm_min  = 6'($urandom_range(0, 60));
      if ($urandom_range(0, 63) == 0) alarm_on = ~alarm_on;
`endif
      @(negedge clk);
    end
    set_valid = 1'b0; alarm_set = 1'b0; reset = 1'b1;
    idle(2);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
